// File: rtl/dual_slope_sequencer.sv
// dual_slope_sequencer
//   Sequencer for a dual-slope integrating ADC front end. One conversion is
//   auto-zero (AZ), fixed-time input integration (INT) and timed
//   de-integration against the reference (DEINT), followed by a one-cycle
//   DONE pulse.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-low reset
//   start_i               conversion request, sampled in IDLE only
//   range_req_i/mode_req_i range/mode latched on an accepted start
//   comp_i, sat_hi_i, sat_lo_i, ref_ok_i
//                         asynchronous analog status, 2-flop synchronised
//   afe_reset_o, afe_sel_o, ref_sign_o, range_sel_o, mode_sel_o
//                         analog control pins
//   busy_o, done_o        AZ/INT/DEINT indicator, completion pulse
//   result_o, polarity_o, overrange_o, fault_o
//                         conversion result and status, held until next start
module dual_slope_sequencer #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned T_ZERO = 1000,
  parameter int unsigned T_INT  = 10000,
  parameter int unsigned T_MAX  = 20000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             range_req_i,
  input  logic             mode_req_i,
  input  logic             comp_i,
  input  logic             sat_hi_i,
  input  logic             sat_lo_i,
  input  logic             ref_ok_i,
  output logic             afe_reset_o,
  output logic             afe_sel_o,
  output logic             ref_sign_o,
  output logic             range_sel_o,
  output logic             mode_sel_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] result_o,
  output logic             polarity_o,
  output logic             overrange_o,
  output logic             fault_o
);

  localparam logic [CNT_W-1:0] ZERO_LAST = CNT_W'(T_ZERO - 1);
  localparam logic [CNT_W-1:0] INT_LAST  = CNT_W'(T_INT - 1);
  localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(T_MAX - 1);
  localparam logic [CNT_W-1:0] MAX_VAL   = CNT_W'(T_MAX);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AZ,
    S_INT,
    S_DEINT,
    S_DONE
  } state_e;

  // Synchroniser bit order: {ref_ok, sat_lo, sat_hi, comp}
  logic [3:0] sync1_q, sync2_q;
  logic       comp_s, sat_hi_s, sat_lo_s, ref_ok_s;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {ref_ok_i, sat_lo_i, sat_hi_i, comp_i};
      sync2_q <= sync1_q;
    end
  end

  assign comp_s   = sync2_q[0];
  assign sat_hi_s = sync2_q[1];
  assign sat_lo_s = sync2_q[2];
  assign ref_ok_s = sync2_q[3];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             range_q, range_d;
  logic             mode_q, mode_d;
  logic             polarity_q, polarity_d;
  logic             overrange_q, overrange_d;
  logic             fault_q, fault_d;
  logic             afe_reset_q, afe_reset_d;
  logic             afe_sel_q, afe_sel_d;
  logic             ref_sign_q, ref_sign_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + ONE;
    result_d    = result_q;
    range_d     = range_q;
    mode_d      = mode_q;
    polarity_d  = polarity_q;
    overrange_d = overrange_q;
    fault_d     = fault_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          result_d    = '0;
          polarity_d  = 1'b0;
          overrange_d = 1'b0;
          if (ref_ok_s) begin
            range_d = range_req_i;
            mode_d  = mode_req_i;
            fault_d = 1'b0;
            state_d = S_AZ;
          end else begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_AZ: begin
        if (cnt_q == ZERO_LAST) begin
          cnt_d   = '0;
          state_d = S_INT;
        end
      end
      S_INT: begin
        if (cnt_q == INT_LAST) begin
          polarity_d = comp_s;
          cnt_d      = '0;
          state_d    = S_DEINT;
        end
      end
      S_DEINT: begin
        // Crossing is tested first so it wins over a coincident timeout.
        // The two-cycle synchroniser lag is removed from the count.
        if (comp_s != polarity_q) begin
          result_d = (cnt_q >= TWO) ? (cnt_q - TWO) : '0;
          cnt_d    = '0;
          state_d  = S_DONE;
        end else if (cnt_q == MAX_LAST) begin
          overrange_d = 1'b1;
          result_d    = MAX_VAL;
          cnt_d       = '0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Aborts override the phase decision above; a lost reference outranks
    // saturation and leaves overrange clear.
    if (state_q inside {S_AZ, S_INT, S_DEINT}) begin
      if (!ref_ok_s) begin
        fault_d     = 1'b1;
        overrange_d = 1'b0;
        polarity_d  = polarity_q;
        result_d    = '0;
        cnt_d       = '0;
        state_d     = S_DONE;
      end else if (sat_hi_s || sat_lo_s) begin
        overrange_d = 1'b1;
        polarity_d  = polarity_q;
        result_d    = MAX_VAL;
        cnt_d       = '0;
        state_d     = S_DONE;
      end
    end

    // Control pins are decoded from the next state so they register
    // alongside it.
    afe_reset_d = state_d inside {S_IDLE, S_AZ, S_DONE};
    afe_sel_d   = (state_d == S_DEINT);
    ref_sign_d  = (state_d == S_DEINT) && polarity_d;
    busy_d      = state_d inside {S_AZ, S_INT, S_DEINT};
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      range_q     <= 1'b0;
      mode_q      <= 1'b0;
      polarity_q  <= 1'b0;
      overrange_q <= 1'b0;
      fault_q     <= 1'b0;
      afe_reset_q <= 1'b1;
      afe_sel_q   <= 1'b0;
      ref_sign_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      range_q     <= range_d;
      mode_q      <= mode_d;
      polarity_q  <= polarity_d;
      overrange_q <= overrange_d;
      fault_q     <= fault_d;
      afe_reset_q <= afe_reset_d;
      afe_sel_q   <= afe_sel_d;
      ref_sign_q  <= ref_sign_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign afe_reset_o = afe_reset_q;
  assign afe_sel_o   = afe_sel_q;
  assign ref_sign_o  = ref_sign_q;
  assign range_sel_o = range_q;
  assign mode_sel_o  = mode_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign polarity_o  = polarity_q;
  assign overrange_o = overrange_q;
  assign fault_o     = fault_q;

endmodule

// File: tb/tb_dual_slope_sequencer.sv
module tb_dual_slope_sequencer;

  localparam int CW = 16;
  localparam int TZ = 4;
  localparam int TI = 16;
  localparam int TM = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          range_req_i;
  logic          mode_req_i;
  logic          comp_i;
  logic          sat_hi_i;
  logic          sat_lo_i;
  logic          ref_ok_i;
  logic          afe_reset_o;
  logic          afe_sel_o;
  logic          ref_sign_o;
  logic          range_sel_o;
  logic          mode_sel_o;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] result_o;
  logic          polarity_o;
  logic          overrange_o;
  logic          fault_o;

  dual_slope_sequencer #(
    .CNT_W (CW),
    .T_ZERO(TZ),
    .T_INT (TI),
    .T_MAX (TM)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .range_req_i(range_req_i),
    .mode_req_i (mode_req_i),
    .comp_i     (comp_i),
    .sat_hi_i   (sat_hi_i),
    .sat_lo_i   (sat_lo_i),
    .ref_ok_i   (ref_ok_i),
    .afe_reset_o(afe_reset_o),
    .afe_sel_o  (afe_sel_o),
    .ref_sign_o (ref_sign_o),
    .range_sel_o(range_sel_o),
    .mode_sel_o (mode_sel_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .polarity_o (polarity_o),
    .overrange_o(overrange_o),
    .fault_o    (fault_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural integrator: shorted by afe_reset, integrates vin when
  // afe_sel=0, and the signed reference when afe_sel=1.
  int vin   = 0;
  int vref  = 0;
  int integ = 0;

  always @(negedge clk_i) begin
    if (afe_reset_o)     integ = 0;
    else if (!afe_sel_o) integ = integ + vin;
    else if (ref_sign_o) integ = integ - vref;
    else                 integ = integ + vref;
  end

  assign comp_i = (integ > 0);

  typedef struct {
    logic [CW-1:0] result;
    logic          pol;
    logic          ovr;
    logic          flt;
    int            lat;
    int            busy;
    int            deint;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  int   obs_lat, obs_busy, obs_deint, obs_rs_hi;
  bit   obs_afe_moved, obs_timeout;
  logic obs_done_next, obs_done_rs;

  localparam logic [9:0] IDLE_VEC = 10'b1000000000;

  function automatic logic [9:0] out_vec();
    return {afe_reset_o, afe_sel_o, ref_sign_o, range_sel_o, mode_sel_o,
            busy_o, done_o, polarity_o, overrange_o, fault_o};
  endfunction

  task automatic push_exp(input int res, input logic pol, input logic ovr,
                          input logic flt, input int lat, input int deint);
    exp_t e;
    e.result = CW'(res);
    e.pol    = pol;
    e.ovr    = ovr;
    e.flt    = flt;
    e.lat    = lat;
    e.busy   = lat - 1;
    e.deint  = deint;
    sb.push_back(e);
  endtask

  task automatic settle();
    start_i  = 1'b0;
    sat_hi_i = 1'b0;
    sat_lo_i = 1'b0;
    ref_ok_i = 1'b1;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Observes one conversion from the cycle after the accepted start up to
  // done_o; n counts cycles since acceptance. Optional stimulus pokes:
  // a start at n==poke_at, ref_ok drop from n==drop_at, 3-cycle sat_hi at
  // n==sat_at (0 disables each).
  task automatic wait_done(input int poke_at, input int drop_at, input int sat_at);
    int n;
    n = 1;
    obs_busy = 0; obs_deint = 0; obs_rs_hi = 0;
    obs_afe_moved = 0; obs_timeout = 0;
    forever begin
      if (busy_o === 1'b1) obs_busy++;
      if (afe_sel_o === 1'b1) begin
        obs_deint++;
        if (ref_sign_o === 1'b1) obs_rs_hi++;
      end
      if (afe_reset_o !== 1'b1 || afe_sel_o !== 1'b0) obs_afe_moved = 1;
      if (done_o === 1'b1) break;
      if (n >= 300) begin
        obs_timeout = 1;
        break;
      end
      start_i = (n == poke_at);
      if (drop_at != 0) ref_ok_i = (n < drop_at);
      sat_hi_i = (sat_at != 0) && (n >= sat_at) && (n < sat_at + 3);
      @(negedge clk_i);
      n++;
    end
    obs_lat     = n;
    obs_done_rs = ref_sign_o;
    start_i     = 1'b0;
    sat_hi_i    = 1'b0;
    @(negedge clk_i);
    obs_done_next = done_o;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    checks++; if (out_vec() !== IDLE_VEC) begin errors++; $display("FAIL reset_outputs got %b exp %b", out_vec(), IDLE_VEC); end
    checks++; if (result_o !== '0) begin errors++; $display("FAIL reset_result got %0d exp 0", result_o); end
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++; if (out_vec() !== IDLE_VEC) begin errors++; $display("FAIL reset_release_idle got %b exp %b", out_vec(), IDLE_VEC); end
  endtask

  task automatic test_positive();
    exp_t e;
    settle();
    vin = 15; vref = 22; range_req_i = 1'b1; mode_req_i = 1'b0;
    push_exp(10, 1'b1, 1'b0, 1'b0, TZ + TI + 13 + 1, 13);
    do_start();
    wait_done(0, 0, 0);
    e = sb.pop_front();
    checks++; if (obs_timeout) begin errors++; $display("FAIL pos_timeout got no done exp done"); end
    checks++; if (result_o !== e.result) begin errors++; $display("FAIL pos_result got %0d exp %0d", result_o, e.result); end
    checks++; if (polarity_o !== e.pol) begin errors++; $display("FAIL pos_polarity got %b exp %b", polarity_o, e.pol); end
    checks++; if ({overrange_o, fault_o} !== {e.ovr, e.flt}) begin errors++; $display("FAIL pos_flags got %b%b exp %b%b", overrange_o, fault_o, e.ovr, e.flt); end
    checks++; if (obs_lat != e.lat) begin errors++; $display("FAIL pos_latency got %0d exp %0d", obs_lat, e.lat); end
    checks++; if (obs_busy != e.busy) begin errors++; $display("FAIL pos_busy_cycles got %0d exp %0d", obs_busy, e.busy); end
    checks++; if (obs_rs_hi != e.deint) begin errors++; $display("FAIL pos_ref_sign got %0d exp %0d", obs_rs_hi, e.deint); end
    checks++; if (obs_done_next !== 1'b0 || obs_done_rs !== 1'b0) begin errors++; $display("FAIL pos_done_pulse got next=%b rs=%b exp 0 0", obs_done_next, obs_done_rs); end
    checks++; if ({range_sel_o, mode_sel_o} !== 2'b10) begin errors++; $display("FAIL pos_range_mode got %b%b exp 10", range_sel_o, mode_sel_o); end
  endtask

  task automatic test_fault_idle();
    exp_t e;
    settle();
    ref_ok_i = 1'b0;
    repeat (3) @(negedge clk_i);
    push_exp(0, 1'b0, 1'b0, 1'b1, 1, 0);
    do_start();
    wait_done(0, 0, 0);
    e = sb.pop_front();
    checks++; if (obs_timeout) begin errors++; $display("FAIL fidle_timeout got no done exp done"); end
    checks++; if (result_o !== e.result) begin errors++; $display("FAIL fidle_result got %0d exp %0d", result_o, e.result); end
    checks++; if ({overrange_o, fault_o} !== {e.ovr, e.flt}) begin errors++; $display("FAIL fidle_flags got %b%b exp %b%b", overrange_o, fault_o, e.ovr, e.flt); end
    checks++; if (obs_lat != e.lat || obs_busy != e.busy) begin errors++; $display("FAIL fidle_timing got lat=%0d busy=%0d exp lat=%0d busy=%0d", obs_lat, obs_busy, e.lat, e.busy); end
    checks++; if (obs_afe_moved) begin errors++; $display("FAIL fidle_afe_idle got moved exp idle"); end
  endtask

  task automatic test_negative();
    exp_t e;
    settle();
    vin = -15; vref = 48; range_req_i = 1'b0; mode_req_i = 1'b1;
    push_exp(5, 1'b0, 1'b0, 1'b0, TZ + TI + 8 + 1, 8);
    do_start();
    wait_done(0, 0, 0);
    e = sb.pop_front();
    checks++; if (obs_timeout) begin errors++; $display("FAIL neg_timeout got no done exp done"); end
    checks++; if (result_o !== e.result) begin errors++; $display("FAIL neg_result got %0d exp %0d", result_o, e.result); end
    checks++; if (polarity_o !== e.pol) begin errors++; $display("FAIL neg_polarity got %b exp %b", polarity_o, e.pol); end
    checks++; if ({overrange_o, fault_o} !== {e.ovr, e.flt}) begin errors++; $display("FAIL neg_flags got %b%b exp %b%b", overrange_o, fault_o, e.ovr, e.flt); end
    checks++; if (obs_lat != e.lat || obs_deint != e.deint) begin errors++; $display("FAIL neg_timing got lat=%0d deint=%0d exp lat=%0d deint=%0d", obs_lat, obs_deint, e.lat, e.deint); end
    checks++; if (obs_rs_hi != 0) begin errors++; $display("FAIL neg_ref_sign got %0d exp 0", obs_rs_hi); end
    checks++; if ({range_sel_o, mode_sel_o} !== 2'b01) begin errors++; $display("FAIL neg_range_mode got %b%b exp 01", range_sel_o, mode_sel_o); end
  endtask

  task automatic test_no_cross();
    exp_t e;
    settle();
    vin = 15; vref = 0;
    push_exp(TM, 1'b1, 1'b1, 1'b0, TZ + TI + TM + 1, TM);
    do_start();
    wait_done(0, 0, 0);
    e = sb.pop_front();
    checks++; if (obs_timeout) begin errors++; $display("FAIL ovr_timeout got no done exp done"); end
    checks++; if (result_o !== e.result) begin errors++; $display("FAIL ovr_result got %0d exp %0d", result_o, e.result); end
    checks++; if ({overrange_o, fault_o} !== {e.ovr, e.flt}) begin errors++; $display("FAIL ovr_flags got %b%b exp %b%b", overrange_o, fault_o, e.ovr, e.flt); end
    checks++; if (obs_deint != e.deint) begin errors++; $display("FAIL ovr_deint_cycles got %0d exp %0d", obs_deint, e.deint); end
    checks++; if (obs_lat != e.lat || obs_busy != e.busy) begin errors++; $display("FAIL ovr_timing got lat=%0d busy=%0d exp lat=%0d busy=%0d", obs_lat, obs_busy, e.lat, e.busy); end
  endtask

  task automatic test_fault_start();
    exp_t e;
    settle();
    vin = 15; vref = 22;
    push_exp(0, 1'b0, 1'b0, 1'b1, 3, 0);
    ref_ok_i = 1'b0;
    do_start();
    wait_done(0, 0, 0);
    e = sb.pop_front();
    checks++; if (obs_timeout) begin errors++; $display("FAIL fstart_timeout got no done exp done"); end
    checks++; if (result_o !== e.result) begin errors++; $display("FAIL fstart_result got %0d exp %0d", result_o, e.result); end
    checks++; if ({polarity_o, overrange_o, fault_o} !== {e.pol, e.ovr, e.flt}) begin errors++; $display("FAIL fstart_flags got %b%b%b exp %b%b%b", polarity_o, overrange_o, fault_o, e.pol, e.ovr, e.flt); end
    checks++; if (obs_lat != e.lat) begin errors++; $display("FAIL fstart_latency got %0d exp %0d", obs_lat, e.lat); end
    checks++; if (obs_afe_moved) begin errors++; $display("FAIL fstart_afe_idle got moved exp idle"); end
  endtask

  task automatic test_ref_drop_int();
    exp_t e;
    settle();
    vin = 15; vref = 22;
    push_exp(0, 1'b0, 1'b0, 1'b1, 8 + 3, 0);
    do_start();
    wait_done(0, 8, 0);
    e = sb.pop_front();
    checks++; if (obs_timeout) begin errors++; $display("FAIL refdrop_timeout got no done exp done"); end
    checks++; if (result_o !== e.result) begin errors++; $display("FAIL refdrop_result got %0d exp %0d", result_o, e.result); end
    checks++; if ({overrange_o, fault_o} !== {e.ovr, e.flt}) begin errors++; $display("FAIL refdrop_flags got %b%b exp %b%b", overrange_o, fault_o, e.ovr, e.flt); end
    checks++; if (obs_lat != e.lat || obs_deint != e.deint) begin errors++; $display("FAIL refdrop_timing got lat=%0d deint=%0d exp lat=%0d deint=%0d", obs_lat, obs_deint, e.lat, e.deint); end
  endtask

  task automatic test_sat_int();
    exp_t e;
    settle();
    vin = 15; vref = 22;
    push_exp(TM, 1'b0, 1'b1, 1'b0, 8 + 3, 0);
    do_start();
    wait_done(0, 0, 8);
    e = sb.pop_front();
    checks++; if (obs_timeout) begin errors++; $display("FAIL sat_timeout got no done exp done"); end
    checks++; if (result_o !== e.result) begin errors++; $display("FAIL sat_result got %0d exp %0d", result_o, e.result); end
    checks++; if ({overrange_o, fault_o} !== {e.ovr, e.flt}) begin errors++; $display("FAIL sat_flags got %b%b exp %b%b", overrange_o, fault_o, e.ovr, e.flt); end
    checks++; if (obs_lat != e.lat || obs_busy != e.busy) begin errors++; $display("FAIL sat_timing got lat=%0d busy=%0d exp lat=%0d busy=%0d", obs_lat, obs_busy, e.lat, e.busy); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   n;
    bit   saw;
    settle();
    vin = 15; vref = 22; range_req_i = 1'b1; mode_req_i = 1'b1;
    do_start();
    n = 0;
    while (afe_sel_o !== 1'b1 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    checks++; if (afe_sel_o !== 1'b1) begin errors++; $display("FAIL rstmid_reach_deint got afe_sel=%b exp 1", afe_sel_o); end
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++; if (out_vec() !== IDLE_VEC) begin errors++; $display("FAIL rstmid_outputs got %b exp %b", out_vec(), IDLE_VEC); end
    checks++; if (result_o !== '0) begin errors++; $display("FAIL rstmid_result got %0d exp 0", result_o); end
    saw = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (done_o !== 1'b0) saw = 1;
    end
    rst_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      if (done_o !== 1'b0 || busy_o !== 1'b0) saw = 1;
    end
    checks++; if (saw) begin errors++; $display("FAIL rstmid_no_done got activity exp none"); end

    range_req_i = 1'b0; mode_req_i = 1'b1;
    push_exp(10, 1'b1, 1'b0, 1'b0, TZ + TI + 13 + 1, 13);
    do_start();
    range_req_i = 1'b1; mode_req_i = 1'b0;
    wait_done(2, 0, 0);
    e = sb.pop_front();
    checks++; if (obs_timeout) begin errors++; $display("FAIL rec_timeout got no done exp done"); end
    checks++; if (result_o !== e.result) begin errors++; $display("FAIL rec_result got %0d exp %0d", result_o, e.result); end
    checks++; if (obs_lat != e.lat || obs_busy != e.busy) begin errors++; $display("FAIL rec_timing got lat=%0d busy=%0d exp lat=%0d busy=%0d", obs_lat, obs_busy, e.lat, e.busy); end
    checks++; if ({range_sel_o, mode_sel_o} !== 2'b01) begin errors++; $display("FAIL rec_range_mode got %b%b exp 01", range_sel_o, mode_sel_o); end
    checks++; if (obs_done_next !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rec_after_done got done=%b busy=%b exp 0 0", obs_done_next, busy_o); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got no finish exp finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst_i       = 1'b0;
    start_i     = 1'b0;
    range_req_i = 1'b0;
    mode_req_i  = 1'b0;
    sat_hi_i    = 1'b0;
    sat_lo_i    = 1'b0;
    ref_ok_i    = 1'b1;
    test_reset();
    test_positive();
    test_fault_idle();
    test_negative();
    test_no_cross();
    test_fault_start();
    test_ref_drop_int();
    test_sat_int();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
